hazard_ctrl: RTL

Pipeline hazard controller that consumes the execute-side outputs of the decode/execute pipeline register and drives the stall, flush and forwarding controls back toward fetch, decode and the decode/execute register. It detects load-use hazards against the instruction currently in decode and inserts a one-cycle bubble. It flushes wrong-path instructions on taken branch, JAL or JALR resolution and selects operand-forwarding sources for the execute stage. Two saturating performance counters record stall and flush events.

---
 rtl/hazard_ctrl.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, redirect flush, operand forwarding
// select and saturating stall/flush event counters.
module hazard_ctrl #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned CNT_WIDTH    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4:0]            id_rs1,
    input  logic [4:0]            id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [DATA_WIDTH-1:0] ex_instruction,
    input  logic [4:0]            ex_rs1,
    input  logic [4:0]            ex_rs2,
    input  logic                  ex_load,
    input  logic                  ex_reg_write,
    input  logic                  ex_branch,
    input  logic                  ex_branch_result,
    input  logic                  ex_jalr,
    input  logic                  ex_next_sel,
    input  logic [4:0]            mem_rd,
    input  logic [4:0]            wb_rd,
    input  logic                  mem_reg_write,
    input  logic                  wb_reg_write,
    output logic                  stall_pc,
    output logic                  stall_fd,
    output logic                  flush_fd,
    output logic                  flush_de,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel,
    output logic [CNT_WIDTH-1:0]  stall_cnt,
    output logic [CNT_WIDTH-1:0]  flush_cnt
);

    typedef enum logic {StRun, StRedirect} state_e;

    // Cycles still to flush after the redirect cycle itself.
    localparam logic [1:0] FlushInit = 2'(FLUSH_CYCLES - 1);

    state_e               state_q;
    logic [1:0]           flush_left_q;
    logic [CNT_WIDTH-1:0] stall_cnt_q;
    logic [CNT_WIDTH-1:0] flush_cnt_q;

    logic [4:0] ex_rd;
    logic       load_use;
    logic       redirect;
    logic       stall_event;
    logic       redirect_event;
    logic       unused_instr_bits;

    assign ex_rd = ex_instruction[11:7];
    assign unused_instr_bits = ^{ex_instruction[DATA_WIDTH-1:12], ex_instruction[6:0]};

    assign load_use = ex_load & ex_reg_write & (ex_rd != 5'd0) &
                      ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));
    assign redirect = (ex_branch & ex_branch_result) | ex_jalr | ex_next_sel;

    // Execute holds only bubbles while in StRedirect, so hazards are ignored there.
    assign redirect_event = (state_q == StRun) & redirect;
    assign stall_event    = (state_q == StRun) & ~redirect & load_use;

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                           input logic [4:0] m_rd, input logic m_we,
                                           input logic [4:0] w_rd, input logic w_we);
        if (m_we && (m_rd != 5'd0) && (m_rd == rs)) begin
            return 2'b01;
        end else if (w_we && (w_rd != 5'd0) && (w_rd == rs)) begin
            return 2'b10;
        end
        return 2'b00;
    endfunction

    // Combinational stall/flush/forward controls; all forced low while in reset.
    always_comb begin
        stall_pc  = 1'b0;
        stall_fd  = 1'b0;
        flush_fd  = 1'b0;
        flush_de  = 1'b0;
        fwd_a_sel = 2'b00;
        fwd_b_sel = 2'b00;
        if (rst) begin
            if (state_q == StRedirect || redirect) begin
                flush_fd = 1'b1;
                flush_de = 1'b1;
            end else if (load_use) begin
                stall_pc = 1'b1;
                stall_fd = 1'b1;
                flush_de = 1'b1;
            end
            fwd_a_sel = fwd_sel(ex_rs1, mem_rd, mem_reg_write, wb_rd, wb_reg_write);
            fwd_b_sel = fwd_sel(ex_rs2, mem_rd, mem_reg_write, wb_rd, wb_reg_write);
        end
    end

    // Redirect FSM: extends the flush for FLUSH_CYCLES-1 cycles after the redirect.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StRun;
            flush_left_q <= 2'd0;
        end else begin
            case (state_q)
                StRun: begin
                    if (redirect && (FLUSH_CYCLES > 1)) begin
                        state_q      <= StRedirect;
                        flush_left_q <= FlushInit;
                    end
                end
                StRedirect: begin
                    flush_left_q <= flush_left_q - 2'd1;
                    if (flush_left_q == 2'd1) begin
                        state_q <= StRun;
                    end
                end
                default: state_q <= StRun;
            endcase
        end
    end

    // Saturating event counters; flush counts accepted redirects, not flush cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_event && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (redirect_event && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule
